div_unit: RTL

- Multi-cycle radix-2 restoring divider serving the EX stage's div/divu requests.
- It is the responder end of the EX divide handshake. EX holds start plus operands until ready, then drops start.
- Result returns as {remainder, quotient}, which EX writes as {Hi, Lo}.
- One quotient bit per cycle; 32-bit signed and unsigned.

---
 rtl/div_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for EX div/divu (optional DIV_ZERO_FAST_EN)
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
`ifdef DIV_ZERO_FAST_EN
        ,
        S_ZERO = 2'd3
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_dividend;    // dividend magnitude, quotient bits shift in at the bottom
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_rem;
    logic                r_qsign;
    logic                r_rsign;
    logic [2*DATA_W-1:0] r_result;
    logic                r_ready;

    logic                w_accept;
    logic                w_abort;
    logic                w_last;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   w_trial;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;

    assign w_accept = start_i & ~annul_i;
    assign w_abort  = annul_i | ~start_i;
    assign w_last   = (r_cnt == CNT_LAST);

    // Operand magnitudes; 0x80000000 negates to itself, read as unsigned.
    assign w_mag_a = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
    assign w_mag_b = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;

    // One restoring step: bring in the next dividend bit and try subtracting the divisor.
    // When the trial succeeds the difference is below the divisor, so DATA_W bits suffice.
    assign w_shift    = {r_rem, r_dividend[DATA_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_trial    = w_shift[DATA_W-1:0] - r_divisor;
    assign w_rem_next = w_ge ? w_trial : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_dividend[DATA_W-2:0], w_ge};
    assign w_rem_fix  = r_rsign ? (~w_rem_next + ONE) : w_rem_next;
    assign w_quo_fix  = r_qsign ? (~w_quo_next + ONE) : w_quo_next;

    assign result_o = r_result;
    assign ready_o  = r_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; annul or a dropped start always wins over completion.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == '0) begin
                        w_state_next = S_ZERO;
                    end else
`endif
                    begin
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end
            end
`ifdef DIV_ZERO_FAST_EN
            S_ZERO: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign correction and result holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (w_accept) begin
                        r_dividend <= w_mag_a;
                        r_divisor  <= w_mag_b;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_qsign    <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        r_rsign    <= signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
                S_BUSY: begin
                    if (w_abort) begin
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= w_quo_next;
                        r_cnt      <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_abort) begin
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                S_ZERO: begin
                    r_result <= '0;
                    r_ready  <= ~w_abort;
                end
`endif
                default: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

endmodule
